// File: rtl/addr_seq_pkg.sv
// Shared types and mode encodings for the address sequence generators.
package addr_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CIRC   = 1'b1;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/addr_step.sv
// Combinational address step: addr +/- stride, wrapping modulo 2^WIDTH.
module addr_step
    import addr_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] stride,
    input  logic             dir,
    output logic [WIDTH-1:0] next_addr
);

    always_comb begin
        if (dir == DIR_DEC) begin
            next_addr = addr - stride;
        end else begin
            next_addr = addr + stride;
        end
    end

endmodule

// File: rtl/addr_seq_gen.sv
// Burst address generator: loads base/stride/len/mode, then emits one address
// per valid/ready transfer in single or circular mode, incrementing or decrementing.
module addr_seq_gen
    import addr_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LEN_W  = 8,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  d,
    input  logic [WIDTH-1:0]  stride,
    input  logic [LEN_W-1:0]  len,
    input  logic              c,
    input  logic              s,
    input  logic              stop,
    input  logic              ready,
    output logic              valid,
    output logic [WIDTH-1:0]  address,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]    base_q, base_d;
    logic [WIDTH-1:0]    stride_q, stride_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                circ_q, circ_d;
    logic                dir_q, dir_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [WIDTH-1:0]    step_addr;
    logic                last_beat;

    addr_step #(.WIDTH(WIDTH)) u_step (
        .addr      (addr_q),
        .stride    (stride_q),
        .dir       (dir_q),
        .next_addr (step_addr)
    );

    // len_q is never zero in RUN, so len_q-1 cannot underflow there.
    assign last_beat = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        stride_d = stride_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        circ_d   = circ_q;
        dir_d    = dir_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        base_d   = d;
                        stride_d = stride;
                        len_d    = len;
                        circ_d   = c;
                        dir_d    = s;
                        addr_d   = d;
                        cnt_d    = '0;
                        pass_d   = '0;
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // valid is always high in RUN, so ready alone marks a transfer.
                if (ready) begin
                    if (last_beat) begin
                        if (circ_q == MODE_CIRC) begin
                            addr_d = base_q;
                            cnt_d  = '0;
                            if (pass_q != '1) begin
                                pass_d = pass_q + PASS_W'(1);
                            end
                        end else begin
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        addr_d = step_addr;
                        cnt_d  = cnt_q + LEN_W'(1);
                    end
                end
                // Abort wins over a circular wrap but lets the transfer land first.
                if (stop) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            circ_q   <= MODE_SINGLE;
            dir_q    <= DIR_INC;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            circ_q   <= circ_d;
            dir_q    <= dir_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign valid    = valid_q;
    assign address  = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_addr_seq_gen.sv
// Scoreboard bench for addr_seq_gen: directed bursts push expected addresses and
// done pulses; a negedge monitor compares whatever the DUT presents.
module tb_addr_seq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] d;
    logic [15:0] stride;
    logic [7:0]  len;
    logic        c;
    logic        s;
    logic        stop;
    logic        ready;
    logic        valid;
    logic [15:0] address;
    logic        busy;
    logic        done;
    logic [7:0]  pass_cnt;

    typedef struct {
        bit          is_done;
        logic [15:0] addr;
        logic [7:0]  pass;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   errs = 0;

    addr_seq_gen #(.WIDTH(16), .LEN_W(8), .PASS_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .d        (d),
        .stride   (stride),
        .len      (len),
        .c        (c),
        .s        (s),
        .stop     (stop),
        .ready    (ready),
        .valid    (valid),
        .address  (address),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_x(input logic [15:0] a, input logic [7:0] p);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.pass    = p;
        sbq.push_back(e);
    endtask

    task automatic push_done(input logic [7:0] p);
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.pass    = p;
        sbq.push_back(e);
    endtask

    // Returns one time unit after the loading edge.
    task automatic issue(input logic [15:0] bd, input logic [15:0] bs, input logic [7:0] bl,
                         input logic bc, input logic bdir);
        @(posedge clk);
        #1;
        start  = 1'b1;
        d      = bd;
        stride = bs;
        len    = bl;
        c      = bc;
        s      = bdir;
        @(posedge clk);
        #1;
        start  = 1'b0;
        d      = 16'h0;
        stride = 16'h0;
        len    = 8'h0;
        c      = 1'b0;
        s      = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (sbq.size() == 0) return;
            @(posedge clk);
        end
        errs++;
        $display("FAIL %s: timeout, %0d expected items still pending", name, sbq.size());
        sbq.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && done) begin
                errs++;
                $display("FAIL valid_done_overlap: valid=1 done=1 at %0t", $time);
            end
            if (valid) begin
                if (sbq.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_valid: address 0x%0h with empty scoreboard at %0t", address, $time);
                end else if (sbq[0].is_done) begin
                    errs++;
                    $display("FAIL valid_before_done: address 0x%0h while done expected at %0t", address, $time);
                end else begin
                    check("address", 32'(address), 32'(sbq[0].addr));
                    check("pass_cnt_xfer", 32'(pass_cnt), 32'(sbq[0].pass));
                    if (ready) void'(sbq.pop_front());
                end
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_done: done with empty scoreboard at %0t", $time);
                end else if (!sbq[0].is_done) begin
                    errs++;
                    $display("FAIL early_done: done while address 0x%0h expected at %0t", sbq[0].addr, $time);
                end else begin
                    check("pass_cnt_done", 32'(pass_cnt), 32'(sbq[0].pass));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; d = '0; stride = '0; len = '0;
        c = 1'b0; s = 1'b0; stop = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_address", 32'(address), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass_cnt), 0);
        rst = 1'b0;

        // Single increment: four back-to-back addresses, done on the fifth cycle.
        push_x(16'h0002, 0); push_x(16'h0003, 0); push_x(16'h0004, 0); push_x(16'h0005, 0);
        push_done(0);
        issue(16'h0002, 16'h0001, 8'd4, 1'b0, 1'b0);
        check("first_valid_latency", 32'(valid), 1);
        check("busy_in_run", 32'(busy), 1);
        repeat (4) @(posedge clk);
        #1;
        check("done_timing", 32'(done), 1);
        check("busy_after_done", 32'(busy), 0);
        drain("single_inc");

        // Decrement with wrap below zero.
        push_x(16'h0001, 0); push_x(16'hFFFF, 0); push_x(16'hFFFD, 0); push_done(0);
        issue(16'h0001, 16'h0002, 8'd3, 1'b0, 1'b1);
        drain("dec_wrap");

        // Circular with stop on the fifth transfer.
        push_x(16'h0010, 0); push_x(16'h0014, 0); push_x(16'h0010, 1); push_x(16'h0014, 1);
        push_x(16'h0010, 2); push_done(2);
        issue(16'h0010, 16'h0004, 8'd2, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stop_valid_low", 32'(valid), 0);
        check("stop_done", 32'(done), 1);
        @(posedge clk);
        #1;
        check("stop_pass_held", 32'(pass_cnt), 2);
        check("stop_done_one_cycle", 32'(done), 0);
        drain("circ_stop");

        // Backpressure: ready low for three cycles after the first address.
        push_x(16'h00FF, 0); push_x(16'h0100, 0); push_x(16'h0101, 0); push_done(0);
        ready = 1'b0;
        issue(16'h00FF, 16'h0001, 8'd3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_valid_held", 32'(valid), 1);
        ready = 1'b1;
        drain("backpressure");

        // len=0: done only, no valid.
        push_done(0);
        issue(16'h1234, 16'h0001, 8'd0, 1'b0, 1'b0);
        check("len0_done", 32'(done), 1);
        check("len0_busy", 32'(busy), 0);
        drain("len0");

        // Start while busy is ignored.
        push_x(16'h0100, 0); push_x(16'h0200, 0); push_x(16'h0300, 0); push_x(16'h0400, 0);
        push_done(0);
        issue(16'h0100, 16'h0100, 8'd4, 1'b0, 1'b0);
        start = 1'b1; d = 16'h5555; stride = 16'h0003; len = 8'd1; s = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("start_busy");

        // Reset after three transfers, then a fresh burst.
        push_x(16'hF0A3, 0); push_x(16'hF0B3, 0); push_x(16'hF0C3, 0);
        issue(16'hF0A3, 16'h0010, 8'd8, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(valid), 0);
        check("midrst_address", 32'(address), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_pass", 32'(pass_cnt), 0);
        @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done), 0);
        rst = 1'b0;
        check("midrst_sb_empty", 32'(sbq.size()), 0);
        push_x(16'h0040, 0); push_x(16'h0041, 0); push_done(0);
        issue(16'h0040, 16'h0001, 8'd2, 1'b0, 1'b0);
        drain("after_rst");

        repeat (3) @(posedge clk);
        check("final_sb_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
